mmio_uart_tx: RTL and testbench

- Memory-mapped UART transmitter on the single-cycle MIPS computer's data-memory store bus (memwrite, dataadr, writedata), sitting beside dmem.
- Responds to CPU stores at TX_ADDR by queuing the low byte in a FIFO, then serialises queued bytes as 8N1 frames on the tx line.
- Exposes a status word at STAT_ADDR for CPU polling.

---
 rtl/mmio_uart_tx.sv | 176 +++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the CPU data-memory store bus.
// Stores to TX_ADDR queue a byte; STAT_ADDR exposes count/overflow/full/busy.
module mmio_uart_tx #(
    parameter int             n            = 32,
    parameter logic [n-1:0]   TX_ADDR      = 'h0000_0100,
    parameter logic [n-1:0]   STAT_ADDR    = 'h0000_0104,
    parameter int             DEPTH        = 8,
    parameter int             CLKS_PER_BIT = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         memwrite,
    input  logic [n-1:0] dataadr,
    input  logic [n-1:0] writedata,
    output logic [n-1:0] readdata,
    output logic         hit,
    output logic         tx
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state;
    logic [BW-1:0]   baud;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;

    logic [7:0]      mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            overflow;

    logic            push;
    logic            pop;
    logic            accept;
    logic            drop;
    logic            clear_ovf;
    logic            full;
    logic            busy;
    logic            baud_done;
    logic [3:0]      count_field;
    logic            unused_data;

    // Store bus contract: a store acts on the posedge where memwrite is high.
    // There is no backpressure; a store to a full FIFO with no pop on the same
    // edge is discarded and recorded in the sticky overflow flag.
    assign push      = memwrite && (dataadr == TX_ADDR);
    assign clear_ovf = memwrite && (dataadr == STAT_ADDR) && writedata[2];
    assign full      = (count == FULL_COUNT);
    assign pop       = (state == IDLE) && (count != '0);
    assign accept    = push && (!full || pop);
    assign drop      = push && full && !pop;
    assign busy      = (state != IDLE) || (count != '0);
    assign baud_done = (baud == BAUD_LAST);

    assign hit         = (dataadr == TX_ADDR) || (dataadr == STAT_ADDR);
    assign count_field = 4'(count);
    assign unused_data = ^writedata[n-1:8];

    always_comb begin
        readdata = '0;
        if (dataadr == STAT_ADDR) begin
            readdata[6:3] = count_field;
            readdata[2]   = overflow;
            readdata[1]   = full;
            readdata[0]   = busy;
        end
    end

    // Storage array carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= writedata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift <= mem[rd_ptr];
                        baud  <= '0;
                        state <= START;
                        tx    <= 1'b0;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                        tx      <= shift[0];
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            // Drive the next bit now so tx stays a pure register output.
                            shift   <= {1'b0, shift[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shift[1];
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (baud_done) begin
                        baud  <= '0;
                        state <= IDLE;
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: vector table, directed corner sequences, and a
// randomized run checked cycle by cycle against a frame-level line model.
module tb_mmio_uart_tx;

    localparam int          CPB       = 4;
    localparam int          DEPTH     = 8;
    localparam logic [31:0] TX_ADDR   = 32'h0000_0100;
    localparam logic [31:0] STAT_ADDR = 32'h0000_0104;

    logic        clk;
    logic        reset;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        hit;
    logic        tx;

    int checks;
    int errors;

    // Model: queued bytes, sticky overflow, and the frame in flight as
    // (byte, cycles elapsed since its start bit began).
    logic [7:0] exp_q[$];
    bit         m_ovf;
    bit         m_active;
    int         m_off;
    logic [7:0] m_byte;

    typedef struct {
        logic        mw;
        logic [31:0] adr;
        logic [31:0] wd;
        logic        exp_hit;
        logic [31:0] exp_stat;
    } vec_t;

    vec_t vecs[8];

    mmio_uart_tx #(
        .n(32),
        .TX_ADDR(TX_ADDR),
        .STAT_ADDR(STAT_ADDR),
        .DEPTH(DEPTH),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .memwrite(memwrite),
        .dataadr(dataadr),
        .writedata(writedata),
        .readdata(readdata),
        .hit(hit),
        .tx(tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx >= 9) return 1'b1;
        return b[idx-1];
    endfunction

    function automatic logic exp_tx();
        if (!m_active) return 1'b1;
        return frame_bit(m_byte, m_off / CPB);
    endfunction

    function automatic logic [31:0] exp_rd();
        logic [31:0] v;
        v = '0;
        if (dataadr == STAT_ADDR) begin
            v[6:3] = 4'(exp_q.size());
            v[2]   = m_ovf;
            v[1]   = (exp_q.size() == DEPTH);
            v[0]   = m_active || (exp_q.size() != 0);
        end
        return v;
    endfunction

    task automatic model_step();
        bit full_m;
        bit pop_m;
        if (!reset) begin
            exp_q.delete();
            m_ovf    = 1'b0;
            m_active = 1'b0;
            m_off    = 0;
        end else begin
            full_m = (exp_q.size() == DEPTH);
            pop_m  = 1'b0;
            if (m_active) begin
                m_off++;
                if (m_off == 10 * CPB) m_active = 1'b0;
            end else if (exp_q.size() != 0) begin
                m_byte   = exp_q.pop_front();
                m_active = 1'b1;
                m_off    = 0;
                pop_m    = 1'b1;
            end
            if (memwrite && dataadr == TX_ADDR) begin
                if (!full_m || pop_m) exp_q.push_back(writedata[7:0]);
                else m_ovf = 1'b1;
            end else if (memwrite && dataadr == STAT_ADDR && writedata[2]) begin
                m_ovf = 1'b0;
            end
        end
    endtask

    // One clock: check decode, advance the model on the pre-edge inputs,
    // then compare the registered outputs just after the edge.
    task automatic cycle();
        #1;
        check("hit", {31'b0, hit}, {31'b0, (dataadr == TX_ADDR) || (dataadr == STAT_ADDR)});
        model_step();
        @(posedge clk);
        #1;
        check("tx", {31'b0, tx}, {31'b0, exp_tx()});
        check("readdata", readdata, exp_rd());
    endtask

    task automatic reset_dut();
        reset    = 1'b0;
        memwrite = 1'b0;
        cycle();
        cycle();
        reset = 1'b1;
    endtask

    task automatic store(input logic [31:0] adr, input logic [31:0] wd);
        memwrite  = 1'b1;
        dataadr   = adr;
        writedata = wd;
        cycle();
        memwrite = 1'b0;
        dataadr  = STAT_ADDR;
    endtask

    initial begin
        logic [9:0] a5_bits;
        bit         done;
        int         rate;

        checks    = 0;
        errors    = 0;
        reset     = 1'b0;
        memwrite  = 1'b0;
        dataadr   = '0;
        writedata = '0;
        m_ovf     = 1'b0;
        m_active  = 1'b0;
        m_off     = 0;
        m_byte    = '0;

        vecs[0] = '{1'b1, TX_ADDR,       32'h0000_00A5, 1'b1, 32'h0000_0009};
        vecs[1] = '{1'b1, 32'h0000_0054, 32'h0000_0096, 1'b0, 32'h0000_0000};
        vecs[2] = '{1'b1, STAT_ADDR,     32'h0000_0004, 1'b1, 32'h0000_0000};
        vecs[3] = '{1'b0, TX_ADDR,       32'h0000_0011, 1'b1, 32'h0000_0000};
        vecs[4] = '{1'b1, 32'h0000_0108, 32'h0000_0022, 1'b0, 32'h0000_0000};
        vecs[5] = '{1'b1, 32'h0000_0101, 32'h0000_0033, 1'b0, 32'h0000_0000};
        vecs[6] = '{1'b1, TX_ADDR,       32'hFFFF_FF00, 1'b1, 32'h0000_0009};
        vecs[7] = '{1'b1, 32'h0000_0000, 32'h0000_0044, 1'b0, 32'h0000_0000};

        // Reset held with a store strobe active.
        reset     = 1'b0;
        memwrite  = 1'b1;
        dataadr   = TX_ADDR;
        writedata = 32'h0000_005A;
        for (int i = 0; i < 3; i++) cycle();
        check("reset_tx", {31'b0, tx}, 32'h1);
        dataadr = STAT_ADDR;
        #1;
        check("reset_stat", readdata, 32'h0);
        reset    = 1'b1;
        memwrite = 1'b0;
        for (int i = 0; i < 20; i++) cycle();
        check("reset_idle_tx", {31'b0, tx}, 32'h1);

        // Single-store vectors from a clean reset.
        foreach (vecs[i]) begin
            reset_dut();
            memwrite  = vecs[i].mw;
            dataadr   = vecs[i].adr;
            writedata = vecs[i].wd;
            #1;
            check("vec_hit", {31'b0, hit}, {31'b0, vecs[i].exp_hit});
            cycle();
            memwrite = 1'b0;
            dataadr  = STAT_ADDR;
            #1;
            check("vec_stat", readdata, vecs[i].exp_stat);
            check("vec_tx", {31'b0, tx}, 32'h1);
        end

        // Single byte 0xA5: start, LSB-first data, stop, then idle.
        reset_dut();
        store(TX_ADDR, 32'h0000_00A5);
        a5_bits = {1'b1, 8'hA5, 1'b0};
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < CPB; c++) begin
                cycle();
                check("a5_line", {31'b0, tx}, {31'b0, a5_bits[b]});
            end
        end
        cycle();
        check("a5_idle_stat", readdata, 32'h0);

        // Burst of ten stores: one popped, eight queued, last dropped.
        reset_dut();
        for (int i = 1; i <= 10; i++) begin
            memwrite  = 1'b1;
            dataadr   = TX_ADDR;
            writedata = 32'(i);
            cycle();
        end
        memwrite = 1'b0;
        dataadr  = STAT_ADDR;
        #1;
        check("burst_stat", readdata, 32'h0000_0047);

        store(STAT_ADDR, 32'h0000_0004);
        #1;
        check("ovf_clear_stat", readdata, 32'h0000_0043);

        // Push on the very edge the full FIFO pops.
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!m_active && exp_q.size() != 0) begin
                done = 1'b1;
                break;
            end
            cycle();
        end
        if (!done) timeout_fail("wait_full_pop");
        store(TX_ADDR, 32'h0000_0055);
        #1;
        check("full_push_pop_stat", readdata, 32'h0000_0043);

        done = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (!m_active && exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
            cycle();
        end
        if (!done) timeout_fail("wait_drain");
        #1;
        check("drained_stat", readdata, 32'h0);

        // Reset in the middle of data bit 3 with bytes still queued.
        reset_dut();
        store(TX_ADDR, 32'h0000_00C3);
        store(TX_ADDR, 32'h0000_0011);
        store(TX_ADDR, 32'h0000_0022);
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (m_active && m_off == 4 * CPB + 1) begin
                done = 1'b1;
                break;
            end
            cycle();
        end
        if (!done) timeout_fail("wait_bit3");
        reset = 1'b0;
        cycle();
        check("midframe_reset_tx", {31'b0, tx}, 32'h1);
        check("midframe_reset_stat", readdata, 32'h0);
        reset = 1'b1;
        store(TX_ADDR, 32'h0000_003C);
        for (int i = 0; i < 10 * CPB + 2; i++) cycle();
        check("after_reset_frame_stat", readdata, 32'h0);

        // Randomized traffic with varying store rate and rare resets.
        reset_dut();
        for (int i = 0; i < 4000; i++) begin
            rate      = (i < 2000) ? 30 : 4;
            reset     = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
            memwrite  = ($urandom_range(0, 99) < rate);
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: dataadr = TX_ADDR;
                6, 7:             dataadr = STAT_ADDR;
                default:          dataadr = $urandom();
            endcase
            writedata = $urandom();
            cycle();
        end
        reset    = 1'b1;
        memwrite = 1'b0;
        dataadr  = STAT_ADDR;
        for (int i = 0; i < 2000; i++) begin
            if (!m_active && exp_q.size() == 0) break;
            cycle();
        end
        cycle();
        check("final_stat", {28'b0, readdata[3:0]}, {28'b0, 1'b0, m_ovf, 2'b00});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
